// File: rtl/sbox_pkg.sv
// Shared constants and GF(2^8) helpers for the masked AES S-box.
// Holds the reduction polynomial, the AES affine matrix and constant, the pipeline
// latency, and the field multiply / inverse / linear-affine functions.
package sbox_pkg;

  localparam int unsigned SBOX_LATENCY = 5;

  localparam logic [8:0] GfPoly      = 9'h11B;
  localparam logic [7:0] AffineConst = 8'h63;

  // Row i selects the input bits XORed into output bit i (row 0 is the lowest entry).
  localparam logic [7:0][7:0] AffineRows = {
    8'hF8, 8'h7C, 8'h3E, 8'h1F, 8'h8F, 8'hC7, 8'hE3, 8'hF1
  };

  // Shift-and-add multiply in GF(2^8) modulo GfPoly.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = sh[7] ? ((sh << 1) ^ GfPoly[7:0]) : (sh << 1);
    end
    return acc;
  endfunction

  // Inverse as a^254; maps 0 to 0 naturally.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] res;
    logic [7:0] base;
    res  = 8'h01;
    base = gf_mul(a, a);
    for (int i = 1; i < 8; i++) begin
      res  = gf_mul(res, base);
      base = gf_mul(base, base);
    end
    return res;
  endfunction

  // Linear part of the AES affine map (constant added separately, on one share only).
  function automatic logic [7:0] affine(input logic [7:0] x);
    logic [7:0] y;
    y = '0;
    for (int i = 0; i < 8; i++) begin
      y[i] = ^(AffineRows[i] & x);
    end
    return y;
  endfunction

endpackage

// File: rtl/sbox_dom_and.sv
// 1-bit, 2-share DOM-indep AND gate with registered cross-domain terms.
// Ports: clk_i clock, rst_i sync active-high reset, a0_i/a1_i and b0_i/b1_i operand
// shares, z_i fresh random bit, q0_o/q1_o output shares (one cycle after inputs).
module dom_and (
  input  logic clk_i,
  input  logic rst_i,
  input  logic a0_i,
  input  logic a1_i,
  input  logic b0_i,
  input  logic b1_i,
  input  logic z_i,
  output logic q0_o,
  output logic q1_o
);

  logic t00_d, t01_d, t10_d, t11_d;
  logic t00_q, t01_q, t10_q, t11_q;

  // Cross terms are blinded by z before the register so no wire sees both shares.
  always_comb begin
    t00_d = a0_i & b0_i;
    t01_d = (a0_i & b1_i) ^ z_i;
    t11_d = a1_i & b1_i;
    t10_d = (a1_i & b0_i) ^ z_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      t00_q <= 1'b0;
      t01_q <= 1'b0;
      t10_q <= 1'b0;
      t11_q <= 1'b0;
    end else begin
      t00_q <= t00_d;
      t01_q <= t01_d;
      t10_q <= t10_d;
      t11_q <= t11_d;
    end
  end

  always_comb begin
    q0_o = t00_q ^ t01_q;
    q1_o = t11_q ^ t10_q;
  end

endmodule

// File: rtl/sbox.sv
// First-order multiplicatively masked AES S-box, two Boolean shares, 5-cycle pipeline.
// Ports: clk clock, rst sync active-high reset, PRNG 20 fresh random bits per cycle,
// inp shared input byte (share 0 in [15:8], share 1 in [7:0]), SB_out shared S(x).
// Stages: E1-E3 compute the shared zero flag with a DOM AND tree, E4 forms x' and the
// Boolean-to-multiplicative products, E5 inverts in the clear and remasks.
module sbox import sbox_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] PRNG,
  input  logic [15:0] inp,
  output logic [15:0] SB_out
);

  // Zero flag: AND of all bits of ~x; complementing share 0 alone complements x.
  logic [7:0] nx0, nx1;
  logic [3:0] l1_s0, l1_s1;
  logic [1:0] l2_s0, l2_s1;
  logic       dl_s0, dl_s1;

  always_comb begin
    nx0 = ~inp[15:8];
    nx1 = inp[7:0];
  end

  for (genvar g = 0; g < 4; g++) begin : g_layer1
    dom_and u_and (
      .clk_i (clk),
      .rst_i (rst),
      .a0_i  (nx0[2*g]),
      .a1_i  (nx1[2*g]),
      .b0_i  (nx0[2*g+1]),
      .b1_i  (nx1[2*g+1]),
      .z_i   (PRNG[16+g]),
      .q0_o  (l1_s0[g]),
      .q1_o  (l1_s1[g])
    );
  end

  for (genvar g = 0; g < 2; g++) begin : g_layer2
    dom_and u_and (
      .clk_i (clk),
      .rst_i (rst),
      .a0_i  (l1_s0[2*g]),
      .a1_i  (l1_s1[2*g]),
      .b0_i  (l1_s0[2*g+1]),
      .b1_i  (l1_s1[2*g+1]),
      .z_i   (PRNG[16+g]),
      .q0_o  (l2_s0[g]),
      .q1_o  (l2_s1[g])
    );
  end

  dom_and u_layer3 (
    .clk_i (clk),
    .rst_i (rst),
    .a0_i  (l2_s0[0]),
    .a1_i  (l2_s1[0]),
    .b0_i  (l2_s0[1]),
    .b1_i  (l2_s1[1]),
    .z_i   (PRNG[16]),
    .q0_o  (dl_s0),
    .q1_o  (dl_s1)
  );

  // x shares ride alongside the AND tree; index 2 is aligned with the zero flag.
  logic [2:0][7:0] x0_q, x1_q;
  logic [SBOX_LATENCY-2:0] vld_q;

  // Stage-4 next state.
  logic [7:0] xp0, xp1, mask_a, mask_b;
  logic [7:0] ax0_d, ax1_d, bx0_d, bx1_d;
  logic [7:0] ax0_q, ax1_q, bx0_q, bx1_q, a_q, b_q;
  logic       d0_q, d1_q;

  always_comb begin
    xp0    = x0_q[2] ^ {7'b0, dl_s0};
    xp1    = x1_q[2] ^ {7'b0, dl_s1};
    mask_a = PRNG[7:0];
    // Equal mask shares would give r = 0; force r = 1 instead.
    mask_b = (PRNG[15:8] == PRNG[7:0]) ? (PRNG[7:0] ^ 8'h01) : PRNG[15:8];
    ax0_d  = gf_mul(mask_a, xp0);
    ax1_d  = gf_mul(mask_a, xp1);
    bx0_d  = gf_mul(mask_b, xp0);
    bx1_d  = gf_mul(mask_b, xp1);
  end

  // Stage-5 next state: p = r*x' is safe to invert unmasked.
  logic [7:0]  p, inv, y0, y1;
  logic [15:0] sb_out_d;

  always_comb begin
    p   = ax0_q ^ ax1_q ^ bx0_q ^ bx1_q;
    inv = gf_inv(p);
    y0  = gf_mul(a_q, inv) ^ {7'b0, d0_q};
    y1  = gf_mul(b_q, inv) ^ {7'b0, d1_q};
    // Hold zero until the pipeline has refilled after reset.
    sb_out_d = vld_q[SBOX_LATENCY-2] ? {affine(y0) ^ AffineConst, affine(y1)} : 16'h0000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x0_q   <= '0;
      x1_q   <= '0;
      vld_q  <= '0;
      ax0_q  <= '0;
      ax1_q  <= '0;
      bx0_q  <= '0;
      bx1_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      d0_q   <= 1'b0;
      d1_q   <= 1'b0;
      SB_out <= '0;
    end else begin
      x0_q   <= {x0_q[1:0], inp[15:8]};
      x1_q   <= {x1_q[1:0], inp[7:0]};
      vld_q  <= {vld_q[SBOX_LATENCY-3:0], 1'b1};
      ax0_q  <= ax0_d;
      ax1_q  <= ax1_d;
      bx0_q  <= bx0_d;
      bx1_q  <= bx1_d;
      a_q    <= mask_a;
      b_q    <= mask_b;
      d0_q   <= dl_s0;
      d1_q   <= dl_s1;
      SB_out <= sb_out_d;
    end
  end

endmodule

// File: tb/tb_sbox.sv
// Self-checking bench for sbox: scoreboard queue of expected unshared outputs,
// pushed when a byte is driven and popped five edges later.
module tb_sbox;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] PRNG;
  logic [15:0] inp;
  logic [15:0] SB_out;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic [4:0] vld;

  logic [7:0] sbox_ref [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  sbox dut (
    .clk    (clk),
    .rst    (rst),
    .PRNG   (PRNG),
    .inp    (inp),
    .SB_out (SB_out)
  );

  always #5 clk = ~clk;

  // Drive one input byte, optionally push its expectation, advance one edge.
  // due is set when the byte pushed five edges earlier is now on SB_out.
  task automatic cycle(input logic [15:0] in_v, input logic [19:0] prng_v, input bit push,
                       input logic [7:0] e, output bit due);
    inp  = in_v;
    PRNG = prng_v;
    if (push && !rst) exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (rst) begin
      vld = '0;
      exp_q.delete();
    end else begin
      vld = {vld[3:0], push && !rst};
    end
    due = vld[4];
  endtask

  function automatic logic [15:0] rnd16();
    return 16'($urandom());
  endfunction

  function automatic logic [19:0] rnd20();
    return 20'($urandom());
  endfunction

  task automatic test_reset();
    bit due;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(rnd16(), rnd20(), 1'b0, 8'h00, due);
      checks++;
      if (SB_out !== 16'h0000) begin
        failures++;
        $display("FAIL reset: SB_out=%04h expected 0000", SB_out);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_stream();
    logic [15:0] vin  [7] = '{16'hAA00, 16'h3333, 16'h7670, 16'h2222, 16'hA647, 16'hAAAA,
                              16'hA215};
    logic [7:0]  vexp [7] = '{8'hAC, 8'h63, 8'h6F, 8'h63, 8'hF8, 8'h63, 8'hA9};
    logic [7:0]  e, got;
    bit due;
    for (int i = 0; i < 12; i++) begin
      if (i < 7) cycle(vin[i], rnd20(), 1'b1, vexp[i], due);
      else       cycle(rnd16(), rnd20(), 1'b0, 8'h00, due);
      if (due) begin
        e   = exp_q.pop_front();
        got = SB_out[15:8] ^ SB_out[7:0];
        checks++;
        if (got !== e) begin
          failures++;
          $display("FAIL stream: got %02h expected %02h", got, e);
        end
      end
    end
  endtask

  task automatic test_zero_split();
    logic [15:0] vin [3] = '{16'h0000, 16'hFFFF, 16'h5A5A};
    logic [7:0]  e, got;
    bit due;
    for (int i = 0; i < 8; i++) begin
      if (i < 3) cycle(vin[i], rnd20(), 1'b1, 8'h63, due);
      else       cycle(rnd16(), rnd20(), 1'b0, 8'h00, due);
      if (due) begin
        e   = exp_q.pop_front();
        got = SB_out[15:8] ^ SB_out[7:0];
        checks++;
        if (got !== e) begin
          failures++;
          $display("FAIL zero_split: got %02h expected %02h", got, e);
        end
      end
    end
  endtask

  // Mode 0: all-zero PRNG. Mode 1: equal mask shares, forcing the r = 1 fallback.
  task automatic test_fixed_prng();
    logic [7:0]  e, got, s, m, x;
    logic [19:0] pr;
    bit due;
    for (int mode = 0; mode < 2; mode++) begin
      for (int i = 0; i < 261; i++) begin
        m  = 8'($urandom());
        pr = (mode == 0) ? 20'h00000 : {4'($urandom()), m, m};
        if (i < 256) begin
          x = 8'(i);
          s = 8'($urandom());
          cycle({x ^ s, s}, pr, 1'b1, sbox_ref[x], due);
        end else begin
          cycle(rnd16(), pr, 1'b0, 8'h00, due);
        end
        if (due) begin
          e   = exp_q.pop_front();
          got = SB_out[15:8] ^ SB_out[7:0];
          checks++;
          if (got !== e) begin
            failures++;
            $display("FAIL fixed_prng mode%0d: got %02h expected %02h", mode, got, e);
          end
        end
      end
    end
  endtask

  task automatic test_sweep();
    logic [7:0] e, got, s, x;
    bit due;
    for (int i = 0; i < 261; i++) begin
      if (i < 256) begin
        x = 8'(i);
        s = 8'($urandom());
        cycle({x ^ s, s}, rnd20(), 1'b1, sbox_ref[x], due);
      end else begin
        cycle(rnd16(), rnd20(), 1'b0, 8'h00, due);
      end
      if (due) begin
        e   = exp_q.pop_front();
        got = SB_out[15:8] ^ SB_out[7:0];
        checks++;
        if (got !== e) begin
          failures++;
          $display("FAIL sweep: got %02h expected %02h", got, e);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0]  e, got;
    logic [15:0] v;
    bit due;
    for (int i = 0; i < 4; i++) begin
      v = rnd16();
      cycle(v, rnd20(), 1'b1, sbox_ref[v[15:8] ^ v[7:0]], due);
    end
    rst = 1'b1;
    cycle(rnd16(), rnd20(), 1'b0, 8'h00, due);
    checks++;
    if (SB_out !== 16'h0000) begin
      failures++;
      $display("FAIL mid_reset_edge: SB_out=%04h expected 0000", SB_out);
    end
    rst = 1'b0;
    for (int k = 0; k < 13; k++) begin
      v = rnd16();
      if (k < 8) cycle(v, rnd20(), 1'b1, sbox_ref[v[15:8] ^ v[7:0]], due);
      else       cycle(v, rnd20(), 1'b0, 8'h00, due);
      if (due) begin
        e   = exp_q.pop_front();
        got = SB_out[15:8] ^ SB_out[7:0];
        checks++;
        if (got !== e) begin
          failures++;
          $display("FAIL mid_reset_refill: got %02h expected %02h", got, e);
        end
      end else if (k < 4) begin
        checks++;
        if (SB_out !== 16'h0000) begin
          failures++;
          $display("FAIL mid_reset_hold k=%0d: SB_out=%04h expected 0000", k, SB_out);
        end
      end
    end
  endtask

  task automatic test_share_dist();
    logic [7:0] e, got, s;
    bit         seen0 [256];
    bit         seen1 [256];
    int         n0, n1;
    bit         due;
    for (int i = 0; i < 256; i++) begin
      seen0[i] = 1'b0;
      seen1[i] = 1'b0;
    end
    for (int i = 0; i < 1005; i++) begin
      s = 8'($urandom());
      if (i < 1000) cycle({8'h3C ^ s, s}, rnd20(), 1'b1, sbox_ref[8'h3C], due);
      else          cycle(rnd16(), rnd20(), 1'b0, 8'h00, due);
      if (due) begin
        e   = exp_q.pop_front();
        got = SB_out[15:8] ^ SB_out[7:0];
        seen0[SB_out[15:8]] = 1'b1;
        seen1[SB_out[7:0]]  = 1'b1;
        checks++;
        if (got !== e) begin
          failures++;
          $display("FAIL share_xor: got %02h expected %02h", got, e);
        end
      end
    end
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < 256; i++) begin
      if (seen0[i]) n0++;
      if (seen1[i]) n1++;
    end
    // 1000 uniform draws over 256 values cover about 250 of them.
    checks++;
    if (n0 < 200) begin
      failures++;
      $display("FAIL share0_spread: distinct=%0d required>=200", n0);
    end
    checks++;
    if (n1 < 200) begin
      failures++;
      $display("FAIL share1_spread: distinct=%0d required>=200", n1);
    end
  endtask

  initial begin
    rst  = 1'b1;
    inp  = '0;
    PRNG = '0;
    vld  = '0;
    test_reset();
    test_stream();
    test_zero_split();
    test_fixed_prng();
    test_sweep();
    test_mid_reset();
    test_share_dist();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
